mlp_multi_timer: RTL and testbench

Parametrised multi-channel interval timer, Avalon-MM slave on the system interconnect of the DE10-Lite MLP computer. Each of NUM_CH independent channels has a CNT_W-bit down-counter with a programmable period, an optional 16-bit clock prescaler, one-shot or continuous mode, snapshot capture and a maskable timeout interrupt. Firmware uses it for MLP inference/training profiling and periodic scheduling.

---
 rtl/mlp_timer_pkg.sv | 24 ++
 rtl/mlp_multi_timer_if.sv | 21 ++
 rtl/mlp_timer_channel.sv | 131 +++++++++++++
 rtl/mlp_multi_timer.sv | 74 +++++++
 tb/tb_mlp_multi_timer.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mlp_timer_pkg.sv
// rtl/mlp_timer_pkg.sv - register map and bit positions shared by the timer slice
package mlp_timer_pkg;

  localparam int OFF_W     = 3;
  localparam int CH_STRIDE = 1 << OFF_W;

  typedef enum logic [OFF_W-1:0] {
    REG_STATUS   = 3'd0,
    REG_CONTROL  = 3'd1,
    REG_PERIOD   = 3'd2,
    REG_SNAPSHOT = 3'd3,
    REG_PRESCALE = 3'd4
  } reg_off_e;

  localparam int ST_TO  = 0;
  localparam int ST_RUN = 1;

  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;
  localparam int CTL_PSE   = 4;

endpackage

// File: rtl/mlp_multi_timer_if.sv
// rtl/mlp_multi_timer_if.sv - Avalon-MM slave register bus of the multi-channel timer
interface mlp_multi_timer_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic              read_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;

  modport master (
    output address, chipselect, write_n, read_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, read_n, writedata,
    output readdata
  );
endinterface

// File: rtl/mlp_timer_channel.sv
// rtl/mlp_timer_channel.sv - one timer channel: down-counter, prescaler, RUN/TO and its registers
module mlp_timer_channel
  import mlp_timer_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int PRESC_W      = 16,
  parameter int RESET_PERIOD = 49999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  reg_off_e    reg_off,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(RESET_PERIOD);

  logic [CNT_W-1:0]   cnt_q, cnt_d, period_q, period_d, snap_q, snap_d;
  logic [PRESC_W-1:0] presc_q, presc_d, psc_q, psc_d;
  logic               run_q, run_d, to_q, to_d;
  logic               ito_q, ito_d, cont_q, cont_d, pse_q, pse_d;
  logic               tick, to_set;

  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    snap_d   = snap_q;
    presc_d  = presc_q;
    psc_d    = psc_q;
    run_d    = run_q;
    to_d     = to_q;
    ito_d    = ito_q;
    cont_d   = cont_q;
    pse_d    = pse_q;
    to_set   = 1'b0;
    tick     = ~pse_q | (psc_q == presc_q);

    if (run_q) begin
      psc_d = tick ? '0 : psc_q + PRESC_W'(1);
      if (tick) begin
        if (cnt_q == '0) begin
          cnt_d  = period_q;
          to_set = 1'b1;
          if (!cont_q) run_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    end

    // Register writes override the running update; STOP beats START.
    if (wr_en) begin
      case (reg_off)
        REG_STATUS: to_d = 1'b0;
        REG_CONTROL: begin
          ito_d  = wdata[CTL_ITO];
          cont_d = wdata[CTL_CONT];
          pse_d  = wdata[CTL_PSE];
          if (wdata[CTL_STOP]) begin
            run_d = 1'b0;
          end else if (wdata[CTL_START]) begin
            run_d = 1'b1;
            psc_d = '0;
          end
        end
        REG_PERIOD: begin
          period_d = wdata[CNT_W-1:0];
          cnt_d    = wdata[CNT_W-1:0];
          run_d    = 1'b0;
          psc_d    = '0;
        end
        REG_SNAPSHOT: snap_d  = cnt_q;
        REG_PRESCALE: presc_d = wdata[PRESC_W-1:0];
        default: ;
      endcase
    end

    // A timeout landing with a STATUS write is kept so no event is lost.
    if (to_set) to_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= RST_CNT;
      period_q <= RST_CNT;
      snap_q   <= '0;
      presc_q  <= '0;
      psc_q    <= '0;
      run_q    <= 1'b0;
      to_q     <= 1'b0;
      ito_q    <= 1'b0;
      cont_q   <= 1'b0;
      pse_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      snap_q   <= snap_d;
      presc_q  <= presc_d;
      psc_q    <= psc_d;
      run_q    <= run_d;
      to_q     <= to_d;
      ito_q    <= ito_d;
      cont_q   <= cont_d;
      pse_q    <= pse_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_off)
      REG_STATUS: begin
        rdata[ST_RUN] = run_q;
        rdata[ST_TO]  = to_q;
      end
      REG_CONTROL: begin
        rdata[CTL_PSE]  = pse_q;
        rdata[CTL_CONT] = cont_q;
        rdata[CTL_ITO]  = ito_q;
      end
      REG_PERIOD:   rdata[CNT_W-1:0]   = period_q;
      REG_SNAPSHOT: rdata[CNT_W-1:0]   = snap_q;
      REG_PRESCALE: rdata[PRESC_W-1:0] = presc_q;
      default: ;
    endcase
  end

  assign irq = to_q & ito_q;

endmodule

// File: rtl/mlp_multi_timer.sv
// rtl/mlp_multi_timer.sv - multi-channel interval timer: decode, read mux, readdata register, irq
module mlp_multi_timer
  import mlp_timer_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int PRESC_W      = 16,
  parameter int RESET_PERIOD = 49999
) (
  input  logic              clk,
  input  logic              reset_n,
  mlp_multi_timer_if.slave  bus,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec
);

  localparam int ADDR_W = $clog2(NUM_CH) + OFF_W;

  logic [ADDR_W-1:0] addr;
  logic [31:0]       ch_sel;
  reg_off_e          reg_off;
  logic              wr_acc, rd_acc;
  logic [NUM_CH-1:0] wr_sel;
  logic [31:0]       ch_rdata [NUM_CH];
  logic [31:0]       rd_mux;
  logic [31:0]       readdata_q, readdata_d;

  assign addr    = bus.address;
  assign ch_sel  = 32'(addr) >> OFF_W;
  assign reg_off = reg_off_e'(addr[OFF_W-1:0]);
  assign wr_acc  = bus.chipselect & ~bus.write_n;
  assign rd_acc  = bus.chipselect & ~bus.read_n;

  // Channel indices with no instance decode to nothing and read as 0.
  always_comb begin
    wr_sel = '0;
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == 32'(i)) begin
        wr_sel[i] = wr_acc;
        rd_mux    = ch_rdata[i];
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mlp_timer_channel #(
      .CNT_W        (CNT_W),
      .PRESC_W      (PRESC_W),
      .RESET_PERIOD (RESET_PERIOD)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (wr_sel[i]),
      .reg_off (reg_off),
      .wdata   (bus.writedata),
      .rdata   (ch_rdata[i]),
      .irq     (irq_vec[i])
    );
  end

  always_comb begin
    readdata_d = rd_acc ? rd_mux : readdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata_q <= '0;
    else          readdata_q <= readdata_d;
  end

  assign bus.readdata = readdata_q;
  assign irq          = |irq_vec;

endmodule

// File: tb/tb_mlp_multi_timer.sv
// tb/tb_mlp_multi_timer.sv - randomized bench with a behavioural register/timer model
module tb_mlp_multi_timer;
  import mlp_timer_pkg::*;

  localparam int NUM_CH       = 8;
  localparam int CNT_W        = 16;
  localparam int PRESC_W      = 16;
  localparam int RESET_PERIOD = 49999;
  localparam int ADDR_W       = $clog2(NUM_CH) + 3;
  localparam int CMASK        = (1 << CNT_W) - 1;
  localparam int PMASK        = (1 << PRESC_W) - 1;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              irq;
  logic [NUM_CH-1:0] irq_vec;

  mlp_multi_timer_if #(.ADDR_W(ADDR_W)) bus ();

  mlp_multi_timer #(
    .NUM_CH       (NUM_CH),
    .CNT_W        (CNT_W),
    .PRESC_W      (PRESC_W),
    .RESET_PERIOD (RESET_PERIOD)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .irq     (irq),
    .irq_vec (irq_vec)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Behavioural model: what each channel's registers and counter must hold.
  int          m_cnt [NUM_CH], m_per [NUM_CH], m_snap [NUM_CH], m_presc [NUM_CH], m_psc [NUM_CH];
  bit          m_run [NUM_CH], m_to [NUM_CH], m_ito [NUM_CH], m_cont [NUM_CH], m_pse [NUM_CH];
  logic [31:0] m_rd;
  bit          m_rd_chk;

  function automatic logic [31:0] model_read(input int ch, input int off);
    case (off)
      0:       return {30'd0, m_run[ch], m_to[ch]};
      1:       return {27'd0, m_pse[ch], 2'b00, m_cont[ch], m_ito[ch]};
      2:       return 32'(m_per[ch]);
      3:       return 32'(m_snap[ch]);
      4:       return 32'(m_presc[ch]);
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step(input int i, input bit wr, input int off, input logic [31:0] wd);
    bit fire;
    int cnt0;
    fire = 0;
    cnt0 = m_cnt[i];
    if (m_run[i]) begin
      if (!m_pse[i] || m_psc[i] == m_presc[i]) begin
        m_psc[i] = 0;
        if (m_cnt[i] == 0) begin
          m_cnt[i] = m_per[i];
          fire = 1;
          if (!m_cont[i]) m_run[i] = 0;
        end else begin
          m_cnt[i] = m_cnt[i] - 1;
        end
      end else begin
        m_psc[i] = (m_psc[i] + 1) & PMASK;
      end
    end
    if (wr) begin
      case (off)
        0: m_to[i] = 0;
        1: begin
          m_ito[i]  = wd[0];
          m_cont[i] = wd[1];
          m_pse[i]  = wd[4];
          if (wd[3]) m_run[i] = 0;
          else if (wd[2]) begin
            m_run[i] = 1;
            m_psc[i] = 0;
          end
        end
        2: begin
          m_per[i] = int'(wd) & CMASK;
          m_cnt[i] = m_per[i];
          m_run[i] = 0;
          m_psc[i] = 0;
        end
        3: m_snap[i]  = cnt0;
        4: m_presc[i] = int'(wd) & PMASK;
        default: ;
      endcase
    end
    if (fire) m_to[i] = 1;
  endtask

  always @(posedge clk or negedge reset_n) begin
    int  ch, off;
    bit  wr;
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_cnt[i] = RESET_PERIOD; m_per[i] = RESET_PERIOD; m_snap[i] = 0;
        m_presc[i] = 0; m_psc[i] = 0; m_run[i] = 0; m_to[i] = 0;
        m_ito[i] = 0; m_cont[i] = 0; m_pse[i] = 0;
      end
      m_rd = 0;
      m_rd_chk = 0;
    end else begin
      ch  = int'(bus.address) >> 3;
      off = int'(bus.address) & 7;
      wr  = bus.chipselect && !bus.write_n;
      m_rd_chk = bus.chipselect && !bus.read_n;
      if (m_rd_chk) m_rd = model_read(ch, off);
      for (int i = 0; i < NUM_CH; i++) model_step(i, wr && (ch == i), off, bus.writedata);
    end
  end

  always @(negedge clk) begin
    logic [NUM_CH-1:0] exp_vec;
    if (reset_n) begin
      exp_vec = '0;
      for (int i = 0; i < NUM_CH; i++) exp_vec[i] = m_to[i] & m_ito[i];
      check("irq_vec", 32'(irq_vec), 32'(exp_vec));
      check("irq", 32'(irq), 32'(|exp_vec));
      if (m_rd_chk) check("readdata", bus.readdata, m_rd);
    end
  end

  task automatic do_write(input int a, input logic [31:0] d);
    @(negedge clk);
    bus.address = ADDR_W'(a); bus.writedata = d;
    bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic bus_read(input int a, output logic [31:0] d);
    @(negedge clk);
    bus.address = ADDR_W'(a);
    bus.chipselect = 1'b1; bus.read_n = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.read_n = 1'b1;
    d = bus.readdata;
  endtask

  task automatic wait_irq(input int b, input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (irq_vec[b]) break;
    end
  endtask

  function automatic int ra(input int ch, input int off);
    return ch * CH_STRIDE + off;
  endfunction

  initial begin
    logic [31:0] rd;
    int          n, t1, t2;
    logic [31:0] rst_exp [8];
    rst_exp = '{32'd0, 32'd0, 32'd49999, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};

    bus.address = '0; bus.writedata = '0;
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.read_n = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check("irq_after_reset", 32'(irq), 32'd0);

    for (int off = 0; off < 8; off++) begin
      bus_read(ra(0, off), rd);
      check($sformatf("ch0_reset_off%0d", off), rd, rst_exp[off]);
    end

    // Continuous channel, period 9: timeout every 10 clocks.
    do_write(ra(1, 2), 32'd9);
    do_write(ra(1, 1), 32'h7);
    wait_irq(1, 40, n);
    t1 = cyc;
    check("ch1_first_to_latency", 32'(n), 32'd10);
    check("ch1_irq_vec", 32'(irq_vec), 32'h02);
    check("ch1_irq", 32'(irq), 32'd1);
    do_write(ra(1, 0), 32'd0);
    check("ch1_to_cleared", 32'(irq_vec[1]), 32'd0);
    wait_irq(1, 40, n);
    t2 = cyc;
    check("ch1_interval", 32'(t2 - t1), 32'd10);
    do_write(ra(1, 1), 32'h8);
    do_write(ra(1, 0), 32'd0);

    // One-shot with prescaler: 4 ticks of 5 clocks.
    do_write(ra(2, 2), 32'd3);
    do_write(ra(2, 4), 32'd4);
    do_write(ra(2, 1), 32'h15);
    wait_irq(2, 60, n);
    check("ch2_oneshot_latency", 32'(n), 32'd20);
    bus_read(ra(2, 0), rd);
    check("ch2_status_after", rd, 32'h1);
    do_write(ra(2, 3), 32'd0);
    bus_read(ra(2, 3), rd);
    check("ch2_reloaded", rd, 32'd3);
    do_write(ra(2, 0), 32'd0);

    // Snapshot at a known count, then force reload by a PERIOD write.
    do_write(ra(0, 2), 32'd2000);
    do_write(ra(0, 1), 32'h6);
    repeat (765) @(negedge clk);
    do_write(ra(0, 3), 32'd0);
    bus_read(ra(0, 3), rd);
    check("ch0_snapshot_1234", rd, 32'd1234);
    do_write(ra(0, 2), 32'd500);
    bus_read(ra(0, 0), rd);
    check("ch0_run_cleared", rd, 32'd0);
    do_write(ra(0, 3), 32'd0);
    bus_read(ra(0, 3), rd);
    check("ch0_forced_reload", rd, 32'd500);

    // START and STOP together leaves the channel stopped; strobes read 0.
    do_write(ra(3, 1), 32'hC);
    bus_read(ra(3, 0), rd);
    check("ch3_stop_wins", rd, 32'd0);
    bus_read(ra(3, 1), rd);
    check("ch3_strobes_read0", rd, 32'd0);

    // STATUS write on the same edge the timeout sets TO.
    do_write(ra(4, 2), 32'd9);
    do_write(ra(4, 1), 32'h7);
    repeat (8) @(negedge clk);
    do_write(ra(4, 0), 32'd0);
    bus_read(ra(4, 0), rd);
    check("ch4_to_kept", rd, 32'h3);
    do_write(ra(4, 1), 32'h8);
    do_write(ra(4, 0), 32'd0);

    // PERIOD=0 continuous channel runs alongside the long wrap test.
    do_write(ra(5, 2), 32'd0);
    do_write(ra(5, 1), 32'h7);

    // Full-width period: truncation, wrap and reload of 0xFFFF.
    do_write(ra(7, 2), 32'h1FFFF);
    bus_read(ra(7, 2), rd);
    check("ch7_period_trunc", rd, 32'hFFFF);
    do_write(ra(7, 1), 32'h7);
    wait_irq(7, 70000, n);
    check("ch7_wrap_latency", 32'(n), 32'd65536);
    do_write(ra(7, 3), 32'd0);
    bus_read(ra(7, 3), rd);
    check("ch7_after_wrap", rd, 32'hFFFE);
    do_write(ra(7, 1), 32'h8);
    do_write(ra(5, 1), 32'h8);
    for (int off = 5; off < 8; off++) begin
      bus_read(ra(3, off), rd);
      check($sformatf("ch3_unused_off%0d", off), rd, 32'd0);
    end

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      int          off, a;
      logic [31:0] d;
      off = int'($urandom_range(0, 7));
      a   = ra(int'($urandom_range(0, NUM_CH - 1)), off);
      case (off)
        1:       d = $urandom_range(0, 31);
        2:       d = $urandom_range(0, 40);
        4:       d = $urandom_range(0, 5);
        default: d = $urandom;
      endcase
      if ($urandom_range(0, 1) == 1) do_write(a, d);
      else                           bus_read(a, rd);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Asynchronous reset in the middle of a count.
    do_write(ra(0, 2), 32'd100);
    do_write(ra(0, 1), 32'h7);
    repeat (20) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("irq_in_reset", 32'(irq), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus_read(ra(0, 2), rd);
    check("ch0_period_after_rst", rd, 32'd49999);
    bus_read(ra(0, 0), rd);
    check("ch0_status_after_rst", rd, 32'd0);
    repeat (5) @(negedge clk);
    check("irq_after_midreset", 32'(irq_vec), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
